pipelined_regfile: RTL and testbench

PIPELINED_REGFILE -- requirements
Module: pipelined_regfile

---
 rtl/regfile_pkg.sv | 5 +
 rtl/rf_scoreboard.sv | 38 +++
 rtl/pipelined_regfile.sv | 78 +++++++
 tb/tb_pipelined_regfile.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared FSM state type and zero-register index for the pipelined register file
package regfile_pkg;
    typedef enum logic {CLEAR, RUN} state_t;
    localparam int ZERO_REG = 0;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits with a registered popcount of pending writes
// ports: set_en/set_addr mark a register busy, clr_en/clr_addr release it,
//        busy is the full bit vector, pending_cnt the number of set bits
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [AW-1:0]     set_addr,
    input  logic              clr_en,
    input  logic [AW-1:0]     clr_addr,
    output logic [2**AW-1:0]  busy,
    output logic [AW:0]       pending_cnt
);
    logic [2**AW-1:0] busy_d;
    logic inc, dec;
    always_comb begin
        busy_d = busy;
        if (clr_en) busy_d[clr_addr] = 1'b0;
        if (set_en) busy_d[set_addr] = 1'b1;
        busy_d[ZERO_REG] = 1'b0;
        inc = set_en & ~busy[set_addr];
        // a same-index set keeps the bit high, so the release does not count
        dec = clr_en & busy[clr_addr] & ~(set_en & set_addr == clr_addr);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= '0;
            pending_cnt <= '0;
        end else begin
            busy        <= busy_d;
            pending_cnt <= pending_cnt + (AW+1)'(inc) - (AW+1)'(dec);
        end
    end
endmodule

// File: rtl/pipelined_regfile.sv
// pipelined_regfile: 2-read/1-write register file with write-back bypass, issue scoreboard and power-on clear
// ports: rd_addrN/rd_dataN/rd_busyN combinational read ports; iss_valid/iss_rd/iss_ready issue handshake;
//        wb_en/wb_addr/wb_data write-back; ready after clear; pending_cnt busy count; dbg_data mirrors DEBUG_REG
module pipelined_regfile
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int DEBUG_REG     = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr1,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr2,
    output logic [DATA_WIDTH-1:0]    rd_data1,
    output logic [DATA_WIDTH-1:0]    rd_data2,
    output logic                     rd_busy1,
    output logic                     rd_busy2,
    input  logic                     iss_valid,
    input  logic [ADDRESS_WIDTH-1:0] iss_rd,
    output logic                     iss_ready,
    input  logic                     wb_en,
    input  logic [ADDRESS_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0]    wb_data,
    output logic                     ready,
    output logic [ADDRESS_WIDTH:0]   pending_cnt,
    output logic [DATA_WIDTH-1:0]    dbg_data
);
    localparam int AW = ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam logic [AW-1:0] ZERO = AW'(ZERO_REG);
    state_t state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] mem [2**AW];
    logic [2**AW-1:0] busy;
    logic run, wb, hit1, hit2;
    assign run  = state_q == RUN;
    // write-back is ignored while clearing
    assign wb   = run & wb_en;
    assign hit1 = wb & wb_addr == rd_addr1;
    assign hit2 = wb & wb_addr == rd_addr2;
    always_comb begin
        state_d = (state_q == CLEAR && cnt_q == '1) ? RUN : state_q;
        cnt_d   = run ? cnt_q : cnt_q + AW'(1);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (!run) mem[cnt_q] <= '0;
        else if (wb && wb_addr != ZERO) mem[wb_addr] <= wb_data;
    end
    always_comb begin
        rd_data1  = (!run || rd_addr1 == ZERO) ? '0 : hit1 ? wb_data : mem[rd_addr1];
        rd_data2  = (!run || rd_addr2 == ZERO) ? '0 : hit2 ? wb_data : mem[rd_addr2];
        rd_busy1  = run & busy[rd_addr1] & ~hit1;
        rd_busy2  = run & busy[rd_addr2] & ~hit2;
        iss_ready = run & (iss_rd == ZERO | ~busy[iss_rd] | (wb & wb_addr == iss_rd));
        ready     = run;
        dbg_data  = mem[DEBUG_REG];
    end
    rf_scoreboard #(.AW(AW)) u_sb (
        .clk         (clk),
        .rst         (rst),
        .set_en      (iss_valid & iss_ready & iss_rd != ZERO),
        .set_addr    (iss_rd),
        .clr_en      (wb),
        .clr_addr    (wb_addr),
        .busy        (busy),
        .pending_cnt (pending_cnt)
    );
endmodule

// File: tb/tb_pipelined_regfile.sv
// tb_pipelined_regfile: directed stimulus with a queued-expectation scoreboard checked on the falling edge
module tb_pipelined_regfile;
    localparam int S_RD1 = 0, S_RD2 = 1, S_B1 = 2, S_B2 = 3, S_IRDY = 4, S_RDY = 5, S_CNT = 6, S_DBG = 7;
    logic        clk = 1'b0, rst = 1'b1;
    logic [4:0]  rd_addr1 = '0, rd_addr2 = '0, iss_rd = '0, wb_addr = '0;
    logic [31:0] rd_data1, rd_data2, wb_data = '0, dbg_data;
    logic        rd_busy1, rd_busy2, iss_valid = 1'b0, iss_ready, wb_en = 1'b0, ready;
    logic [5:0]  pending_cnt;
    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;
    chk_t q[$];
    chk_t cur;
    int tests = 0, fails = 0;

    pipelined_regfile #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .DEBUG_REG(10)) dut (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ready(ready), .pending_cnt(pending_cnt), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] peek(int s);
        case (s)
            S_RD1:   return rd_data1;
            S_RD2:   return rd_data2;
            S_B1:    return {31'd0, rd_busy1};
            S_B2:    return {31'd0, rd_busy2};
            S_IRDY:  return {31'd0, iss_ready};
            S_RDY:   return {31'd0, ready};
            S_CNT:   return {26'd0, pending_cnt};
            default: return dbg_data;
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0) begin
            cur = q.pop_front();
            tests++;
            if (peek(cur.sel) !== cur.exp) begin
                fails++;
                $display("FAIL %s: got %h, expected %h", cur.name, peek(cur.sel), cur.exp);
            end
        end
    end

    task automatic want(string n, int s, logic [31:0] e);
        q.push_back('{n, s, e});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic release_and_wait();
        rst = 1'b0;
        repeat (31) step();
        want("ready_at_31", S_RDY, 0);
        step();
        want("ready_at_32", S_RDY, 1);
    endtask

    initial begin
        iss_valid = 1'b1;
        step();
        step();
        want("rst_ready", S_RDY, 0);
        want("rst_cnt", S_CNT, 0);
        want("rst_rd1", S_RD1, 0);
        want("rst_busy1", S_B1, 0);
        want("rst_iss_ready_x0", S_IRDY, 0);
        iss_valid = 1'b0;
        step();
        release_and_wait();
        step();
        rd_addr1 = 5; rd_addr2 = 31;
        want("clear_rd1", S_RD1, 0);
        want("clear_rd2", S_RD2, 0);
        want("clear_dbg", S_DBG, 0);
        step();
        wb_en = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
        want("bypass_x5", S_RD1, 32'hDEADBEEF);
        step();
        wb_en = 0;
        want("stored_x5", S_RD1, 32'hDEADBEEF);
        step();
        wb_en = 1; wb_addr = 0; wb_data = 32'h1; rd_addr1 = 0;
        want("x0_bypass_blocked", S_RD1, 0);
        step();
        wb_en = 0;
        want("x0_reads_zero", S_RD1, 0);
        step();
        iss_valid = 1; iss_rd = 7;
        want("issue_x7_ready", S_IRDY, 1);
        want("cnt_before_x7", S_CNT, 0);
        step();
        iss_valid = 0; rd_addr1 = 7;
        want("cnt_x7", S_CNT, 1);
        want("busy_x7", S_B1, 1);
        want("reissue_x7_blocked", S_IRDY, 0);
        step();
        iss_valid = 1;
        want("reissue_x7_still_blocked", S_IRDY, 0);
        step();
        iss_valid = 0; wb_en = 1; wb_addr = 7; wb_data = 32'h77;
        want("wb_x7_busy_drop", S_B1, 0);
        want("wb_x7_iss_ready", S_IRDY, 1);
        want("wb_x7_bypass", S_RD1, 32'h77);
        want("wb_x7_cnt_same_cycle", S_CNT, 1);
        step();
        wb_en = 0;
        want("cnt_after_wb_x7", S_CNT, 0);
        want("busy_after_wb_x7", S_B1, 0);
        want("stored_x7", S_RD1, 32'h77);
        step();
        iss_valid = 1; iss_rd = 3;
        want("issue_x3_ready", S_IRDY, 1);
        step();
        wb_en = 1; wb_addr = 3; wb_data = 32'h33; rd_addr2 = 3;
        want("issue_wb_x3_ready", S_IRDY, 1);
        want("cnt_x3", S_CNT, 1);
        step();
        wb_en = 0; iss_rd = 0; rd_addr1 = 0;
        want("x3_issue_wins_cnt", S_CNT, 1);
        want("x3_issue_wins_busy", S_B2, 1);
        want("issue_x0_ready", S_IRDY, 1);
        want("busy_x0", S_B1, 0);
        step();
        iss_valid = 0;
        want("issue_x0_cnt", S_CNT, 1);
        want("issue_x0_busy_x3", S_B2, 1);
        step();
        wb_en = 1; wb_addr = 10; wb_data = 32'h2A; rd_addr1 = 10;
        want("dbg_no_bypass", S_DBG, 0);
        want("wb_nonbusy_cnt", S_CNT, 1);
        step();
        wb_en = 0;
        want("dbg_x10", S_DBG, 32'h2A);
        want("stored_x10", S_RD1, 32'h2A);
        want("wb_nonbusy_cnt_after", S_CNT, 1);
        step();
        wb_en = 1; wb_addr = 3; wb_data = 32'h3;
        want("wb_x3_busy_drop", S_B2, 0);
        step();
        wb_en = 0; iss_valid = 1; iss_rd = 1;
        want("cnt_x3_released", S_CNT, 0);
        step();
        iss_rd = 2;
        step();
        iss_rd = 3;
        step();
        iss_valid = 0; rd_addr1 = 1;
        want("cnt_three", S_CNT, 3);
        want("busy_x1", S_B1, 1);
        step();
        rst = 1; iss_rd = 0;
        want("midrun_rst_ready", S_RDY, 0);
        want("midrun_rst_cnt", S_CNT, 0);
        want("midrun_rst_busy1", S_B1, 0);
        want("midrun_rst_busy2", S_B2, 0);
        want("midrun_rst_iss_ready", S_IRDY, 0);
        want("midrun_rst_rd1", S_RD1, 0);
        step();
        release_and_wait();
        step();
        want("post_rst_busy1", S_B1, 0);
        want("post_rst_cnt", S_CNT, 0);
        want("post_rst_rd1", S_RD1, 0);
        want("post_rst_rd2", S_RD2, 0);
        want("post_rst_dbg", S_DBG, 0);
        step();
        step();
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain: got %0d pending, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
